// File: rtl/reaction_ctrl_if.sv
// Key inputs and counter-chain controls of the reaction-test sequencer.
interface reaction_ctrl_if;
    logic       start_key;
    logic       hit_key;
    logic       carry_in;
    logic       det_start;
    logic       trig;
    logic       flow;
    logic       led_go;
    logic       foul;
    logic [2:0] state;

    modport master (
        output start_key, hit_key, carry_in,
        input  det_start, trig, flow, led_go, foul, state
    );

    modport slave (
        input  start_key, hit_key, carry_in,
        output det_start, trig, flow, led_go, foul, state
    );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-test sequencer: random wait, GO LED, 1 ms ticks to the dec_counter chain.
// Optional macro FALSE_START_EN: a hit during the random wait ends in the FOUL state.
module reaction_ctrl #(
    parameter int unsigned TICK_DIV     = 12000,
    parameter int unsigned DELAY_MIN_MS = 1000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_n,
    reaction_ctrl_if.slave  bus
);

    localparam int unsigned DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WAIT_W    = $clog2(DELAY_MIN_MS + 2048);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
`ifdef FALSE_START_EN
    localparam bit FALSE_START = 1'b1;
`else
    localparam bit FALSE_START = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_OVER = 3'd4,
        S_FOUL = 3'd5
    } state_e;

    state_e              state_q;
    state_e              state_nxt;
    logic [15:0]         lfsr_q;
    logic [15:0]         lfsr_nxt;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_nxt;
    logic [WAIT_W-1:0]   wait_q;
    logic [WAIT_W-1:0]   wait_nxt;
    logic                det_start_q;
    logic                trig_q;
    logic                flow_q;
    logic                led_go_q;
    logic                foul_q;
    logic                tick_c;
    logic                entry_c;

    assign tick_c  = (div_q == DIV_W'(TICK_DIV - 1));
    assign entry_c = (state_nxt != state_q);

    // Galois LFSR, taps 16,14,13,11; the all-zero state is unreachable from a non-zero seed
    always_comb begin
        lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_key) state_nxt = S_ARM;
            end
            S_ARM: begin
                if (FALSE_START && bus.hit_key)             state_nxt = S_FOUL;
                else if (tick_c && (wait_q <= WAIT_W'(1))) state_nxt = S_RUN;
            end
            S_RUN: begin
                // carry wins over hit: the digits have already wrapped past 9999
                if (bus.carry_in)     state_nxt = S_OVER;
                else if (bus.hit_key) state_nxt = S_DONE;
            end
            S_DONE, S_OVER, S_FOUL: begin
                if (bus.start_key) state_nxt = S_ARM;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Divider restarts on every state change so the first tick lands TICK_DIV cycles after entry
    always_comb begin
        div_nxt  = (entry_c || tick_c) ? '0 : div_q + DIV_W'(1);
        wait_nxt = wait_q;
        if (entry_c && (state_nxt == S_ARM)) begin
            wait_nxt = WAIT_W'(DELAY_MIN_MS) + WAIT_W'(lfsr_q[10:0]);
        end else if ((state_q == S_ARM) && tick_c) begin
            wait_nxt = wait_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            div_q       <= '0;
            wait_q      <= '0;
            det_start_q <= 1'b0;
            trig_q      <= 1'b0;
            flow_q      <= 1'b0;
            led_go_q    <= 1'b0;
            foul_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            lfsr_q      <= lfsr_nxt;
            div_q       <= div_nxt;
            wait_q      <= wait_nxt;
            det_start_q <= entry_c && (state_nxt == S_ARM);
            trig_q      <= (state_q == S_RUN) && (state_nxt == S_RUN) && tick_c;
            flow_q      <= (state_nxt == S_OVER) || (state_nxt == S_FOUL);
            led_go_q    <= (state_nxt == S_RUN);
            foul_q      <= FALSE_START && (state_nxt == S_FOUL);
        end
    end

    assign bus.state     = state_q;
    assign bus.det_start = det_start_q;
    assign bus.trig      = trig_q;
    assign bus.flow      = flow_q;
    assign bus.led_go    = led_go_q;
    assign bus.foul      = foul_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Randomized bench for reaction_ctrl against a cycle-count reference of the test sequence.
module tb_reaction_ctrl;

    localparam int unsigned TICK_DIV     = 4;
    localparam int unsigned DELAY_MIN_MS = 2;
    localparam logic [15:0] SEED         = 16'hACE1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reaction_ctrl_if bus ();

    reaction_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .DELAY_MIN_MS (DELAY_MIN_MS),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int bad_trig  = 0;
    int bad_olap  = 0;
    logic [15:0] m_lfsr;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1 stepped once per clock from the seed
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.trig && (bus.state != 3'd2)) bad_trig <= bad_trig + 1;
            if (bus.trig && bus.det_start)       bad_olap <= bad_olap + 1;
        end
    end

    task automatic drive(input logic s, input logic h, input logic c);
        bus.start_key = s;
        bus.hit_key   = h;
        bus.carry_in  = c;
        @(negedge clk);
        bus.start_key = 1'b0;
        bus.hit_key   = 1'b0;
        bus.carry_in  = 1'b0;
    endtask

    task automatic enter_arm(input logic h, output logic [10:0] l);
        l = m_lfsr[10:0];
        drive(1'b1, h, 1'b0);
        check("arm_state", int'(bus.state), 1);
        check("det_start_hi", int'(bus.det_start), 1);
        check("arm_flow", int'(bus.flow), 0);
        check("arm_foul", int'(bus.foul), 0);
        @(negedge clk);
        check("det_start_lo", int'(bus.det_start), 0);
    endtask

    // n counts clocks since the ARM entry edge
    task automatic wait_run(input logic [10:0] l, input int n0);
        int n;
        n = n0;
        while (!bus.led_go && n < 9000) begin
            if ($urandom_range(7) == 0) drive(1'b1, 1'b0, 1'b0);
            else                        @(negedge clk);
            n++;
        end
        check("arm_wait_cycles", n, (int'(DELAY_MIN_MS) + int'(l)) * int'(TICK_DIV));
        check("run_state", int'(bus.state), 2);
    endtask

    task automatic run_trigs(input int k);
        int cyc;
        int got;
        int gap_bad;
        cyc = 0; got = 0; gap_bad = 0;
        while (got < k && cyc < k * 4 + 8) begin
            if ($urandom_range(5) == 0) drive(1'b1, 1'b0, 1'b0);
            else                        @(negedge clk);
            cyc++;
            if (bus.trig) got++;
            if (bus.trig !== ((cyc % 4) == 0)) gap_bad++;
        end
        check("trig_count", got, k);
        check("trig_spacing", gap_bad, 0);
    endtask

    logic [10:0] l;
    int          k;

    initial begin
        bus.start_key = 1'b0;
        bus.hit_key   = 1'b0;
        bus.carry_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(bus.state), 0);
        check("rst_outs", int'({bus.det_start, bus.trig, bus.flow, bus.led_go, bus.foul}), 0);
        rst_n = 1'b1;
        repeat (int'($urandom_range(5))) @(negedge clk);

        drive(1'b0, 1'b1, 1'b0);
        check("idle_hit_ignored", int'(bus.state), 0);

        enter_arm(1'b0, l);
        for (int i = 0; i < 4; i++) begin
            wait_run(l, 1);
            k = int'($urandom_range(1, 12));
            run_trigs(k);
            repeat (int'($urandom_range(3))) @(negedge clk);
            if ((i % 2) == 0) begin
                drive(1'b0, 1'b1, 1'b0);
                check("done_state", int'(bus.state), 3);
                check("done_led", int'(bus.led_go), 0);
                check("done_trig", int'(bus.trig), 0);
                repeat (6) @(negedge clk);
                check("done_hold", int'(bus.state), 3);
                enter_arm(1'b1, l);
            end else begin
                drive(1'b0, 1'b1, 1'b1);
                check("over_state", int'(bus.state), 4);
                check("over_flow", int'(bus.flow), 1);
                check("over_led", int'(bus.led_go), 0);
                repeat (3) @(negedge clk);
                check("over_flow_hold", int'(bus.flow), 1);
                enter_arm(1'($urandom_range(1)), l);
            end
        end

        repeat (5) @(negedge clk);
        drive(1'b0, 1'b1, 1'b0);
`ifdef FALSE_START_EN
        check("foul_state", int'(bus.state), 5);
        check("foul_flag", int'(bus.foul), 1);
        check("foul_flow", int'(bus.flow), 1);
        check("foul_led", int'(bus.led_go), 0);
        repeat (8) @(negedge clk);
        check("foul_hold", int'(bus.state), 5);
        enter_arm(1'b0, l);
        wait_run(l, 1);
`else
        check("arm_hit_ignored", int'(bus.state), 1);
        check("arm_foul_zero", int'(bus.foul), 0);
        wait_run(l, 7);
`endif

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", int'(bus.state), 0);
        check("async_rst_outs", int'({bus.det_start, bus.trig, bus.flow, bus.led_go, bus.foul}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", int'(bus.state), 0);
        check("post_rst_led", int'(bus.led_go), 0);

        check("trig_only_in_run", bad_trig, 0);
        check("trig_det_overlap", bad_olap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
